esdi_task_sequencer: RTL and testbench

- Converts one multi-sector read request into a sequence of per-sector task writes into the ESDI sector-timing block's task register, over an AXI4-Lite master port.
- Polls that block's tasks-pending register before each write, so its task FIFO never holds more than MAX_PENDING entries.
- Handles wrap-around at the end of the track.
- Sits between the software/DMA command path and the sector-timing CSR slave.

---
 rtl/esdi_task_sequencer_if.sv | 25 ++
 rtl/esdi_task_sequencer.sv | 126 ++++++++++++
 tb/tb_esdi_task_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/esdi_task_sequencer_if.sv
// esdi_task_sequencer_if: AXI4-Lite master port toward the sector-timing CSR slave.
interface esdi_task_sequencer_if;
    logic        awvalid, awready;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    modport master(
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport slave(
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/esdi_task_sequencer.sv
// esdi_task_sequencer: splits a multi-sector read into per-sector task writes,
// throttled by polling the sector-timing block's tasks-pending register.
module esdi_task_sequencer #(
    parameter int unsigned MAX_PENDING = 64,
    parameter logic [15:0] POLL_GAP    = 16'd16,
    parameter logic [4:0]  TASK_ADDR   = 5'h18
) (
    input  logic                         csr_aclk,
    input  logic                         csr_aresetn,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [15:0]                  req_start_sector,
    input  logic [15:0]                  req_count,
    input  logic [15:0]                  sectors_per_track,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    esdi_task_sequencer_if.master        m
);
    typedef enum logic [2:0] {IDLE, POLL_AR, POLL_R, WAIT, WRITE, WRITE_B, DONE} state_t;
    state_t      state;
    logic [15:0] cur_sector, remaining, spt, gap_cnt;
    logic        abort_pend, stop, bad_req, unused_rdata;
    assign req_ready    = state == IDLE;
    assign busy         = state != IDLE;
    assign done         = state == DONE;
    assign stop         = abort | abort_pend;
    assign bad_req      = sectors_per_track == 16'd0 || req_start_sector >= sectors_per_track;
    assign m.awprot     = 3'b0;
    assign m.arprot     = 3'b0;
    assign m.wstrb      = 4'hF;
    assign unused_rdata = ^m.rdata[31:7];
    always_ff @(posedge csr_aclk) begin
        if (!csr_aresetn) begin
            state      <= IDLE;
            error      <= 1'b0;
            abort_pend <= 1'b0;
            cur_sector <= '0;
            remaining  <= '0;
            spt        <= '0;
            gap_cnt    <= '0;
            m.awvalid  <= 1'b0;
            m.wvalid   <= 1'b0;
            m.bready   <= 1'b0;
            m.arvalid  <= 1'b0;
            m.rready   <= 1'b0;
            m.awaddr   <= '0;
            m.araddr   <= '0;
            m.wdata    <= '0;
        end else begin
            if (state != IDLE && abort) abort_pend <= 1'b1;
            case (state)
                IDLE: if (req_valid) begin
                    cur_sector <= req_start_sector;
                    remaining  <= req_count;
                    spt        <= sectors_per_track;
                    abort_pend <= 1'b0;
                    error      <= req_count != 16'd0 && bad_req;
                    if (req_count == 16'd0 || bad_req) state <= DONE;
                    else begin
                        state     <= POLL_AR;
                        m.arvalid <= 1'b1;
                        m.araddr  <= TASK_ADDR;
                    end
                end
                POLL_AR: if (m.arready) begin
                    m.arvalid <= 1'b0;
                    m.rready  <= 1'b1;
                    state     <= POLL_R;
                end
                POLL_R: if (m.rvalid) begin
                    m.rready <= 1'b0;
                    if (m.rresp != 2'b00) begin
                        error <= 1'b1;
                        state <= DONE;
                    end else if ({25'd0, m.rdata[6:0]} >= MAX_PENDING) begin
                        state   <= stop ? DONE : WAIT;
                        gap_cnt <= POLL_GAP;
                    end else begin
                        state     <= WRITE;
                        m.awvalid <= 1'b1;
                        m.wvalid  <= 1'b1;
                        m.awaddr  <= TASK_ADDR;
                        m.wdata   <= {16'h0, cur_sector};
                    end
                end
                WAIT: begin
                    gap_cnt <= gap_cnt - 16'd1;
                    if (gap_cnt <= 16'd1) begin
                        state     <= stop ? DONE : POLL_AR;
                        m.arvalid <= !stop;
                        m.araddr  <= TASK_ADDR;
                    end
                end
                WRITE: begin
                    if (m.awready) m.awvalid <= 1'b0;
                    if (m.wready) m.wvalid <= 1'b0;
                    // both channels finished, either earlier or on this edge
                    if ((!m.awvalid || m.awready) && (!m.wvalid || m.wready)) begin
                        state    <= WRITE_B;
                        m.bready <= 1'b1;
                    end
                end
                WRITE_B: if (m.bvalid) begin
                    m.bready <= 1'b0;
                    if (m.bresp != 2'b00) begin
                        error <= 1'b1;
                        state <= DONE;
                    end else begin
                        cur_sector <= (cur_sector + 16'd1 == spt) ? 16'd0 : cur_sector + 16'd1;
                        remaining  <= remaining - 16'd1;
                        if (remaining == 16'd1 || stop) state <= DONE;
                        else begin
                            state     <= POLL_AR;
                            m.arvalid <= 1'b1;
                            m.araddr  <= TASK_ADDR;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_esdi_task_sequencer.sv
// tb_esdi_task_sequencer: directed requests against a scripted CSR slave; expected
// task writes and completion status are queued by stimulus and checked by a monitor.
module tb_esdi_task_sequencer;
    logic        csr_aclk = 1'b0;
    logic        csr_aresetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_start_sector = '0;
    logic [15:0] req_count = '0;
    logic [15:0] sectors_per_track = '0;
    logic        abort = 1'b0;
    logic        busy, done, error;
    esdi_task_sequencer_if bus();

    esdi_task_sequencer dut (
        .csr_aclk(csr_aclk), .csr_aresetn(csr_aresetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_start_sector(req_start_sector), .req_count(req_count),
        .sectors_per_track(sectors_per_track), .abort(abort),
        .busy(busy), .done(done), .error(error), .m(bus)
    );

    always #5 csr_aclk = ~csr_aclk;

    int vectors = 0, miscompares = 0;
    int n_reads, n_writes, n_idle, aw_hi, w_hi;
    int aw_stall = 0, aw_cnt = 0;
    int poll_q[$], bresp_q[$];
    logic [31:0] exp_wdata[$];
    logic        exp_err[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // scripted slave: ideal AR/W ready, optional AW stall, queued read data and B responses
    initial begin
        bus.arready = 1'b1; bus.wready = 1'b1; bus.awready = 1'b1;
        bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
        bus.bvalid = 1'b0; bus.bresp = 2'b00;
        forever begin
            @(negedge csr_aclk);
            #1;
            if (bus.rvalid && !bus.rready) bus.rvalid = 1'b0;
            else if (!bus.rvalid && bus.rready) begin
                bus.rvalid = 1'b1;
                bus.rdata = poll_q.size() > 0 ? poll_q.pop_front() : 0;
            end
            if (bus.bvalid && !bus.bready) bus.bvalid = 1'b0;
            else if (!bus.bvalid && bus.bready) begin
                bus.bvalid = 1'b1;
                bus.bresp = bresp_q.size() > 0 ? 2'(bresp_q.pop_front()) : 2'b00;
            end
            if (!bus.awvalid) begin
                aw_cnt = 0;
                bus.awready = aw_stall == 0;
            end else begin
                aw_cnt++;
                bus.awready = aw_cnt >= aw_stall;
            end
        end
    end

    // monitor: pops expectations whenever the DUT presents a write or a done pulse
    initial begin
        forever begin
            @(negedge csr_aclk);
            if (csr_aresetn) begin
                if (busy && !(bus.arvalid || bus.rready || bus.awvalid || bus.wvalid || bus.bready)) n_idle++;
                if (bus.awvalid) aw_hi++;
                if (bus.wvalid) w_hi++;
                if (bus.arvalid && bus.arready) begin
                    n_reads++;
                    chk("araddr", 32'(bus.araddr), 32'h18);
                end
                if (bus.wvalid && bus.wready) begin
                    n_writes++;
                    chk("awaddr", 32'(bus.awaddr), 32'h18);
                    chk("wstrb", 32'(bus.wstrb), 32'hF);
                    if (exp_wdata.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_write: got %0h, expected none", bus.wdata);
                    end else chk("wdata", bus.wdata, exp_wdata.pop_front());
                end
                if (done) begin
                    if (exp_err.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_done: got done, expected none");
                    end else chk("error_at_done", 32'(error), 32'(exp_err.pop_front()));
                end
            end
        end
    end

    task automatic run(input logic [15:0] s, input logic [15:0] c, input logic [15:0] t,
                       input int e_reads, input int e_writes, input int e_idle, input int e_lat);
        int lat;
        bit got;
        n_reads = 0; n_writes = 0; n_idle = 0; aw_hi = 0; w_hi = 0;
        @(negedge csr_aclk);
        chk("req_ready_idle", 32'(req_ready), 32'h1);
        req_start_sector = s; req_count = c; sectors_per_track = t; req_valid = 1'b1;
        @(negedge csr_aclk);
        req_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                got = 1'b1;
                lat = i;
                break;
            end
            @(negedge csr_aclk);
        end
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout: got no done, expected done within 3000 cycles");
        end
        if (e_lat >= 0) chk("done_latency", lat, e_lat);
        @(negedge csr_aclk);
        chk("done_one_cycle", 32'(done), 32'h0);
        chk("busy_after", 32'(busy), 32'h0);
        chk("reads", n_reads, e_reads);
        chk("writes", n_writes, e_writes);
        chk("idle_cycles", n_idle, e_idle);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge csr_aclk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_valids", {27'd0, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 32'h0);
        chk("rst_addr", {22'd0, bus.awaddr, bus.araddr}, 32'h0);
        chk("rst_wdata", bus.wdata, 32'h0);
        csr_aresetn = 1'b1;

        exp_wdata = {32'd5, 32'd6, 32'd7}; exp_err = {1'b0};
        run(16'd5, 16'd3, 16'd32, 3, 3, 1, -1);

        exp_wdata = {32'd30, 32'd31, 32'd0, 32'd1}; exp_err = {1'b0};
        run(16'd30, 16'd4, 16'd32, 4, 4, 1, -1);

        poll_q = {64, 64, 10};
        exp_wdata = {32'd7}; exp_err = {1'b0};
        run(16'd7, 16'd1, 16'd32, 3, 1, 33, -1);
        chk("aw_cycles_poll", aw_hi, 1);

        aw_stall = 5;
        exp_wdata = {32'd0}; exp_err = {1'b0};
        run(16'd0, 16'd1, 16'd8, 1, 1, 1, -1);
        chk("aw_hold", aw_hi, 5);
        chk("w_hold", w_hi, 1);
        aw_stall = 0;

        bresp_q = {0, 2};
        exp_wdata = {32'd10, 32'd11}; exp_err = {1'b1};
        run(16'd10, 16'd4, 16'd32, 2, 2, 1, -1);
        chk("error_sticky", 32'(error), 32'h1);

        exp_err = {1'b0};
        run(16'd3, 16'd0, 16'd32, 0, 0, 1, 0);
        chk("error_cleared", 32'(error), 32'h0);

        exp_err = {1'b1};
        run(16'd40, 16'd2, 16'd32, 0, 0, 1, 0);
        exp_err = {1'b1};
        run(16'd0, 16'd1, 16'd0, 0, 0, 1, 0);

        aw_stall = 5;
        exp_wdata = {32'd3}; exp_err = {1'b0};
        fork
            run(16'd3, 16'd5, 16'd32, 1, 1, 1, -1);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge csr_aclk);
                    if (bus.awvalid) break;
                end
                abort = 1'b1;
                @(negedge csr_aclk);
                abort = 1'b0;
            end
        join
        chk("abort_no_error", 32'(error), 32'h0);
        aw_stall = 0;

        chk("wdata_queue_empty", exp_wdata.size(), 0);
        chk("done_queue_empty", exp_err.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
